// File: rtl/ifmap_row_packer_pkg.sv
// ---------------------------------------------------------------------------
// ifmap_row_packer_pkg
//   Definitions shared by the row packer and the IFMap buffer that consumes
//   its tagged words: row-boundary tag codes, the packer state encoding and
//   a helper that maps first/last-column flags to a tag.
// ---------------------------------------------------------------------------
package ifmap_row_packer_pkg;

  // Row-boundary tags carried in the upper bits of every packed word.
  localparam logic [1:0] TAG_MID       = 2'b00;
  localparam logic [1:0] TAG_ROW_END   = 2'b01;
  localparam logic [1:0] TAG_ROW_START = 2'b10;
  localparam logic [1:0] TAG_SINGLE    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A one-pixel row is both first and last, which gets its own code.
  function automatic logic [1:0] row_tag(input logic first, input logic last);
    logic [1:0] t;
    t = TAG_MID;
    if (first && last) t = TAG_SINGLE;
    else if (first)    t = TAG_ROW_START;
    else if (last)     t = TAG_ROW_END;
    return t;
  endfunction

endpackage : ifmap_row_packer_pkg

// File: rtl/ifmap_row_packer_tagger.sv
// ---------------------------------------------------------------------------
// ifmap_tagger
//   Purely combinational: derives the row-boundary tag of the pixel at
//   column `col` in a row of `row_len` pixels.
//   Ports:
//     col     in  ROW_LEN_SIZE  column of the current pixel (0-based)
//     row_len in  ROW_LEN_SIZE  pixels per row (non-zero while in use)
//     tag     out TAG_WIDTH     row tag for this pixel
// ---------------------------------------------------------------------------
module ifmap_tagger
  import ifmap_row_packer_pkg::*;
#(
  parameter int ROW_LEN_SIZE = 5,
  parameter int TAG_WIDTH    = 2
) (
  input  logic [ROW_LEN_SIZE-1:0] col,
  input  logic [ROW_LEN_SIZE-1:0] row_len,
  output logic [TAG_WIDTH-1:0]    tag
);

  logic first_col;
  logic last_col;

  always_comb begin
    first_col = (col == '0);
    last_col  = (col == row_len - ROW_LEN_SIZE'(1));
    tag       = TAG_WIDTH'(row_tag(first_col, last_col));
  end

endmodule : ifmap_tagger

// File: rtl/ifmap_row_packer.sv
// ---------------------------------------------------------------------------
// ifmap_row_packer
//   Accepts a frame of pixels (num_rows rows of row_len pixels), tags each
//   pixel with its row position and packs up to PAR_WRITE tagged words into
//   one wide IFMap buffer write. A short final group is written with fewer
//   valid words; unused slots are zero.
//   Ports:
//     clk        in   clock, all state on the rising edge
//     rst        in   asynchronous active-low reset
//     start      in   begin a frame (only honoured while idle)
//     row_len    in   pixels per row, sampled with start
//     num_rows   in   rows per frame, sampled with start
//     pix_in     in   pixel data
//     pix_valid  in   pixel offered
//     pix_ready  out  packer can accept a pixel this cycle
//     buf_full   in   buffer cannot take a write this cycle
//     ifmap_out  out  packed {tag, pixel} words, word 0 in the LSBs
//     wen_ifmap  out  buffer write strobe
//     wr_count   out  number of valid words in ifmap_out
//     done       out  one-cycle frame-complete pulse
// ---------------------------------------------------------------------------
module ifmap_row_packer
  import ifmap_row_packer_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int TAG_WIDTH    = 2,
  parameter int PAR_WRITE    = 14,
  parameter int ROW_LEN_SIZE = 5
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [ROW_LEN_SIZE-1:0]                     row_len,
  input  logic [ROW_LEN_SIZE-1:0]                     num_rows,
  input  logic [DATA_WIDTH-1:0]                       pix_in,
  input  logic                                        pix_valid,
  output logic                                        pix_ready,
  input  logic                                        buf_full,
  output logic [(TAG_WIDTH+DATA_WIDTH)*PAR_WRITE-1:0] ifmap_out,
  output logic                                        wen_ifmap,
  output logic [$clog2(PAR_WRITE+1)-1:0]              wr_count,
  output logic                                        done
);

  localparam int W  = TAG_WIDTH + DATA_WIDTH;
  localparam int GW = W * PAR_WRITE;
  localparam int CW = $clog2(PAR_WRITE + 1);

  state_e                  state_q,     state_d;
  logic [ROW_LEN_SIZE-1:0] col_q,       col_d;
  logic [ROW_LEN_SIZE-1:0] row_q,       row_d;
  logic [ROW_LEN_SIZE-1:0] row_len_q,   row_len_d;
  logic [ROW_LEN_SIZE-1:0] num_rows_q,  num_rows_d;
  logic [GW-1:0]           group_q,     group_d;
  logic [CW-1:0]           cnt_q,       cnt_d;
  // Set when the group being filled holds the frame's final pixel, so the
  // write that drains it ends the frame.
  logic                    last_grp_q,  last_grp_d;

  logic [TAG_WIDTH-1:0] tag;
  logic [W-1:0]         word;
  logic                 pix_accept;
  logic                 col_last;
  logic                 row_last;
  logic                 frame_end;

  ifmap_tagger #(
    .ROW_LEN_SIZE (ROW_LEN_SIZE),
    .TAG_WIDTH    (TAG_WIDTH)
  ) u_tagger (
    .col     (col_q),
    .row_len (row_len_q),
    .tag     (tag)
  );

  // Outputs are decoded from registered state only.
  assign pix_ready = (state_q == ST_FILL);
  assign wen_ifmap = (state_q == ST_WRITE) && !buf_full;
  assign done      = (state_q == ST_DONE);
  assign ifmap_out = group_q;
  assign wr_count  = cnt_q;

  always_comb begin
    // NOTE: every variable assigned here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    row_len_d  = row_len_q;
    num_rows_d = num_rows_q;
    group_d    = group_q;
    cnt_d      = cnt_q;
    last_grp_d = last_grp_q;

    word       = {tag, pix_in};
    pix_accept = pix_valid && (state_q == ST_FILL);
    col_last   = (col_q == row_len_q  - ROW_LEN_SIZE'(1));
    row_last   = (row_q == num_rows_q - ROW_LEN_SIZE'(1));
    frame_end  = col_last && row_last;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((row_len != '0) && (num_rows != '0)) begin
            state_d    = ST_FILL;
            row_len_d  = row_len;
            num_rows_d = num_rows;
            col_d      = '0;
            row_d      = '0;
            cnt_d      = '0;
            group_d    = '0;
            last_grp_d = 1'b0;
          end else begin
            // An empty frame completes immediately without any write.
            state_d = ST_DONE;
          end
        end
      end

      ST_FILL: begin
        if (pix_accept) begin
          for (int k = 0; k < PAR_WRITE; k++) begin
            if (cnt_q == CW'(k)) group_d[k*W +: W] = word;
          end
          cnt_d = cnt_q + CW'(1);
          if (col_last) begin
            col_d = '0;
            row_d = row_q + ROW_LEN_SIZE'(1);
          end else begin
            col_d = col_q + ROW_LEN_SIZE'(1);
          end
          last_grp_d = frame_end;
          if (frame_end || (cnt_q == CW'(PAR_WRITE - 1))) state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // Group and count hold until the buffer actually takes the write.
        if (!buf_full) begin
          group_d = '0;
          cnt_d   = '0;
          state_d = last_grp_q ? ST_DONE : ST_FILL;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the group register is reset as well, so a frame aborted by
      // reset leaves nothing stale on ifmap_out.
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      row_len_q  <= '0;
      num_rows_q <= '0;
      group_q    <= '0;
      cnt_q      <= '0;
      last_grp_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed in the combinational block.
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_len_q  <= row_len_d;
      num_rows_q <= num_rows_d;
      group_q    <= group_d;
      cnt_q      <= cnt_d;
      last_grp_q <= last_grp_d;
    end
  end

endmodule : ifmap_row_packer

// File: doc/ifmap_row_packer.md
IFMAP_ROW_PACKER -- requirements
Module: ifmap_row_packer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 16, pixel width; TAG_WIDTH, default 2, row-tag width; PAR_WRITE, default 14, words per buffer write; ROW_LEN_SIZE, default 5, width of row-length and row-count inputs.
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: start  input  1  begins a frame when idle.
REQ-005 SHALL have ports: row_len  input  ROW_LEN_SIZE  pixels per row, sampled on start.
REQ-006 SHALL have ports: num_rows  input  ROW_LEN_SIZE  rows per frame, sampled on start.
REQ-007 SHALL have ports: pix_in  input  DATA_WIDTH  pixel; pix_valid  input  1  pixel offered; pix_ready  output  1  pixel accepted when valid&ready.
REQ-008 SHALL have ports: buf_full  input  1  IFMap buffer cannot take a write this cycle.
REQ-009 SHALL have ports: ifmap_out  output  (TAG_WIDTH+DATA_WIDTH)*PAR_WRITE  packed tagged words; wen_ifmap  output  1  write strobe; wr_count  output  $clog2(PAR_WRITE+1)  valid words in ifmap_out; done  output  1  frame complete pulse.

Function
REQ-010 SHALL form each word as {tag, pixel}: tag 2'b10 for first pixel of a row, 2'b01 for last, 2'b11 when row_len==1, 2'b00 otherwise.
REQ-011 SHALL pack words LSB-first: k-th accepted word of a group occupies bits [(k+1)*W-1 : k*W], W=TAG_WIDTH+DATA_WIDTH; unfilled slots SHALL be zero.
REQ-012 SHALL implement states IDLE, FILL, WRITE, DONE.
REQ-013 IDLE: start=1 with row_len>0 and num_rows>0 -> FILL, latching row_len/num_rows and clearing counters; start with either zero -> DONE; start outside IDLE SHALL be ignored.
REQ-014 FILL: pix_ready=1; each accepted pixel appended; on PAR_WRITE-th word or last pixel of frame -> WRITE next cycle.
REQ-015 WRITE: pix_ready=0; wen_ifmap = !buf_full (combinational from registered state); ifmap_out and wr_count SHALL remain stable until the write cycle; after write, group cleared -> FILL if pixels remain, else DONE.
REQ-016 DONE: done=1 for exactly one cycle, then IDLE.
REQ-017 Latency: wen_ifmap SHALL assert no earlier than the cycle after the accepting edge of the group's final pixel, and exactly then when buf_full=0.
REQ-018 Column counter SHALL wrap to 0 after row_len-1 and increment row counter; frame end = last column of row num_rows-1.
REQ-019 Partial final group SHALL be written with wr_count<PAR_WRITE; full groups SHALL have wr_count=PAR_WRITE.
REQ-020 pix_valid=1 in IDLE, WRITE or DONE SHALL not be consumed.
REQ-021 buf_full held high SHALL stall WRITE indefinitely with no data loss.

Reset
REQ-022 rst=0 SHALL immediately force IDLE, clear counters and group register; outputs: pix_ready=0, wen_ifmap=0, wr_count=0, ifmap_out=0, done=0.
REQ-023 Reset mid-frame SHALL discard the partial group without issuing a write.

Structure
REQ-024 Tag constants (TAG_ROW_START, TAG_ROW_END, TAG_MID, TAG_SINGLE) and the state enum SHALL reside in the shared package used by the IFMap buffer.
REQ-025 A sub-module ifmap_tagger (combinational: column, row_len -> tag) is natural; all sequencing stays in ifmap_row_packer.

Verification
REQ-026 row_len=7, num_rows=2, pixels 1..14, buf_full=0 -> one write, wr_count=14, word0={10,1}, word6={01,7}, word7={10,8}, word13={01,14}; done one cycle later.
REQ-027 row_len=7, num_rows=3, pixels 1..21 -> writes of 14 then 7 words; second group word6={01,21}, slots 7..13 zero.
REQ-028 buf_full high for 5 cycles during WRITE -> wen_ifmap stays 0, pix_ready stays 0, ifmap_out unchanged; write occurs the cycle buf_full drops.
REQ-029 row_len=1, num_rows=3 -> three words tagged 2'b11, single write wr_count=3.
REQ-030 rst low after 5 pixels accepted -> no write, all outputs zero; new start then packs from word0.
REQ-031 Random pix_valid gaps on REQ-026 stimulus -> identical packed output.
